// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate into RV32I I/S/B/U/J fields over a template word,
// flags unrepresentable values, one register stage with valid/ready and saturating stats.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_sel,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  input  logic             clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [31:0] field, mask, enc;
  logic err, accept, hs;
  // mask selects the bits the format owns; everything else comes from the template
  always_comb begin
    field = '0;
    mask  = '0;
    err   = 1'b1;
    case (imm_sel)
      3'd0: begin
        mask  = 32'hFFF0_0000;
        field = {imm[11:0], 20'b0};
        err   = !(&imm[31:11] || ~|imm[31:11]);
      end
      3'd1: begin
        mask  = 32'hFE00_0F80;
        field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        err   = !(&imm[31:11] || ~|imm[31:11]);
      end
      3'd2: begin
        mask  = 32'hFE00_0F80;
        field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        err   = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      end
      3'd3: begin
        mask  = 32'hFFFF_F000;
        field = {imm[31:12], 12'b0};
        err   = |imm[11:0];
      end
      3'd4: begin
        mask  = 32'hFFFF_F000;
        field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        err   = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      end
      default: ;
    endcase
    enc = (base_inst & ~mask) | field;
  end
  assign out_valid = state == FULL;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_inst  <= '0;
      out_err   <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        state    <= FULL;
        out_inst <= enc;
        out_err  <= err;
      end else if (hs) begin
        state <= EMPTY;
      end
      if (clr) begin
        enc_count <= '0;
        err_count <= '0;
      end else if (hs) begin
        enc_count <= enc_count + {{(CNT_W-1){1'b0}}, ~&enc_count};
        err_count <= err_count + {{(CNT_W-1){1'b0}}, out_err && !(&err_count)};
      end
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and random scoreboard bench for imm_encoder,
// run on a 16-bit-counter instance and a 4-bit-counter instance in parallel.
module tb_imm_encoder;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, clr = 0;
  logic [2:0] imm_sel = 0;
  logic [31:0] imm = 0, base_inst = 0;
  logic in_ready, out_valid, out_err, in_ready4, out_valid4, out_err4;
  logic [31:0] out_inst, out_inst4;
  logic [15:0] enc_count, err_count;
  logic [3:0] enc4, err4;
  int n_assert = 0, n_fail = 0, exp_enc = 0, exp_err = 0;
  bit chk_on = 0;
  typedef struct {
    logic [2:0] sel;
    logic [31:0] imm;
    logic [31:0] inst;
    logic err;
  } beat_t;
  beat_t q[$];
  beat_t mb, pb;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .imm_sel(imm_sel),
    .imm(imm), .base_inst(base_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .clr(clr), .enc_count(enc_count), .err_count(err_count)
  );
  imm_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .imm_sel(imm_sel),
    .imm(imm), .base_inst(base_inst), .out_valid(out_valid4), .out_ready(out_ready),
    .out_inst(out_inst4), .out_err(out_err4), .clr(clr), .enc_count(enc4), .err_count(err4)
  );

  always #5 clk = ~clk;

  function automatic int sat(int v, int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction

  function automatic void model(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b,
                                output logic [31:0] inst, output logic e);
    int signed sv;
    sv = v;
    case (s)
      3'd0: begin inst = {v[11:0], b[19:0]}; e = !(sv >= -2048 && sv <= 2047); end
      3'd1: begin inst = {v[11:5], b[24:12], v[4:0], b[6:0]}; e = !(sv >= -2048 && sv <= 2047); end
      3'd2: begin
        inst = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
        e = !(sv >= -4096 && sv <= 4095) || v[0];
      end
      3'd3: begin inst = {v[31:12], b[11:0]}; e = v[11:0] != 0; end
      3'd4: begin
        inst = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
        e = !(sv >= -(1 << 20) && sv <= (1 << 20) - 1) || v[0];
      end
      default: begin inst = b; e = 1'b1; end
    endcase
  endfunction

  function automatic logic [31:0] decode(logic [2:0] s, logic [31:0] i);
    case (s)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: return {i[31:12], 12'b0};
      3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop on output handshake, push on accept, track counters
  always @(negedge clk) if (chk_on) begin
    check("enc_count", enc_count, sat(exp_enc, 16));
    check("err_count", err_count, sat(exp_err, 16));
    check("enc_count4", enc4, sat(exp_enc, 4));
    check("err_count4", err4, sat(exp_err, 4));
    if (rst) begin
      q.delete();
      exp_enc = 0;
      exp_err = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", out_valid, 0);
        else begin
          mb = q.pop_front();
          check("out_inst", out_inst, mb.inst);
          check("out_err", out_err, mb.err);
          check("out_inst4", out_inst4, mb.inst);
          if (!mb.err) check("roundtrip", decode(mb.sel, out_inst), mb.imm);
        end
      end
      if (clr) begin
        exp_enc = 0;
        exp_err = 0;
      end else if (out_valid && out_ready) begin
        exp_enc++;
        if (out_err) exp_err++;
      end
      if (in_valid && in_ready) begin
        pb.sel = imm_sel;
        pb.imm = imm;
        model(imm_sel, imm, base_inst, pb.inst, pb.err);
        q.push_back(pb);
      end
    end
  end

  task automatic send(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b, input bit rnd);
    bit done = 0;
    imm_sel = s;
    imm = v;
    base_inst = b;
    in_valid = 1;
    for (int t = 0; t < 200 && !done; t++) begin
      if (rnd) out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      done = in_ready;
      if (!done) begin @(posedge clk); #1; end
    end
    if (!done) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    for (int t = 0; t < 50 && (q.size() != 0 || out_valid); t++) @(posedge clk);
    #1 check("drain", q.size(), 0);
  endtask

  initial begin
    logic [31:0] v;
    logic [2:0] s;
    repeat (2) @(posedge clk);
    #1 chk_on = 1;
    check("rst_valid", out_valid, 0);
    check("rst_inst", out_inst, 0);
    check("rst_err", out_err, 0);
    check("rst_ready", in_ready, 1);
    check("rst_enc", enc_count, 0);
    check("rst_errc", err_count, 0);
    rst = 0;
    send(3'd0, 32'hFFFF_F800, 32'h0000_0013, 0);
    check("i_valid", out_valid, 1);
    check("i_inst", out_inst, 32'h8000_0013);
    check("i_err", out_err, 0);
    send(3'd2, 32'h0000_0FFE, 32'h0000_0063, 0);
    check("b_inst", out_inst, 32'h7E00_0FE3);
    check("b_err", out_err, 0);
    send(3'd2, 32'h0000_1000, 32'h0000_0063, 0);
    check("b_hi_inst", out_inst, 32'h8000_0063);
    check("b_hi_err", out_err, 1);
    send(3'd4, 32'h0000_0003, 32'h0000_006F, 0);
    check("j_odd_err", out_err, 1);
    send(3'd3, 32'h1234_5000, 32'h0000_0037, 0);
    check("u_inst", out_inst, 32'h1234_5037);
    check("u_err", out_err, 0);
    send(3'd5, 32'h0000_0123, 32'hABCD_EF01, 0);
    check("ill_inst", out_inst, 32'hABCD_EF01);
    check("ill_err", out_err, 1);
    drain();
    out_ready = 0;
    send(3'd0, 32'h0000_0005, 32'h0000_0013, 0);
    imm_sel = 3'd1;
    imm = 32'h0000_0010;
    base_inst = 32'h0000_2023;
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      check("hold_ready", in_ready, 0);
      check("hold_inst", out_inst, 32'h0050_0013);
    end
    @(posedge clk);
    #1 out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_ready", in_ready, 1);
      @(posedge clk);
      #1 imm = i * 4;
      check("stream_valid", out_valid, 1);
    end
    in_valid = 0;
    drain();
    for (int i = 0; i < 1000; i++) begin
      case ($urandom % 4)
        0: v = $urandom;
        1: v = $urandom_range(0, 8191) - 4096;
        2: v = $urandom & 32'hFFFF_F000;
        default: v = $urandom_range(0, (1 << 22) - 1) - (1 << 21);
      endcase
      s = ($urandom % 10) < 8 ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      send(s, v, $urandom, 1);
    end
    drain();
    check("rand_enc", enc_count, sat(exp_enc, 16));
    clr = 1;
    @(posedge clk);
    #1 clr = 0;
    for (int i = 0; i < 20; i++) send(3'd0, i, 32'h13, 0);
    drain();
    check("sat_enc16", enc_count, 20);
    check("sat_enc4", enc4, 15);
    send(3'd0, 32'h1, 32'h13, 0);
    clr = 1;
    @(posedge clk);
    #1 clr = 0;
    check("clr_hs_enc", enc_count, 0);
    check("clr_hs_enc4", enc4, 0);
    out_ready = 0;
    send(3'd3, 32'h0000_1000, 32'h37, 0);
    check("full_before_rst", out_valid, 1);
    rst = 1;
    @(posedge clk);
    #1 check("rst_full_valid", out_valid, 0);
    check("rst_full_ready", in_ready, 1);
    check("rst_full_inst", out_inst, 0);
    rst = 0;
    out_ready = 1;
    send(3'd1, 32'hFFFF_FFFF, 32'h0000_2023, 0);
    check("post_rst_inst", out_inst, 32'hFE00_2FA3);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
